sensor_conditioner: RTL and testbench

Input conditioning stage between the raw smoke/temperature sensor pins and the alarm state machine. Synchronises each asynchronous sensor line into the divided system clock, debounces it with a per-channel consecutive-sample counter, and delivers clean levels plus one-cycle rising-edge pulses. Also keeps a saturating count of rejected glitches for display and diagnostics. Runs on the divided clock, `CLK_clk_o` of the top level.

---
 rtl/sensor_conditioner.sv | 98 +++++++++
 tb/tb_sensor_conditioner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: two-flop synchroniser, consecutive-sample debouncer and
// rising-edge pulse generator for the temperature and smoke sensor lines,
// plus a shared saturating counter of rejected glitches.
module sensor_conditioner #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic       CLK_clk_i,
  input  logic       RST_rst_i,
  input  logic       Sensor_Temp_i,
  input  logic       Sensor_Humo_i,
  output logic       Temp_lvl_o,
  output logic       Humo_lvl_o,
  output logic       Temp_rise_o,
  output logic       Humo_rise_o,
  output logic [7:0] Glitch_cnt_o
);

  // Count value at which the next differing sample is the accepting one.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Channel 0 is temperature, channel 1 is smoke.
  logic [1:0] w_raw;
  logic [1:0] w_lvl;
  logic [1:0] w_rise;
  logic [1:0] w_glitch;
  logic [7:0] r_gcnt;
  logic [8:0] w_gsum;

  assign w_raw = {Sensor_Humo_i, Sensor_Temp_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic             r_s1;
      logic             r_s2;
      logic             r_stable;
      logic             r_rise;
      logic [CNT_W-1:0] r_cnt;
      logic             w_diff;
      logic             w_accept;

      assign w_diff   = r_s2 ^ r_stable;
      assign w_accept = w_diff && (r_cnt == DB_LAST);
      // A run of differing samples broken before acceptance is a glitch.
      assign w_glitch[gi] = !w_diff && (r_cnt != '0);

      // Synchronise the raw line, count consecutive differing samples, accept.
      always_ff @(posedge CLK_clk_i or negedge RST_rst_i) begin
        if (!RST_rst_i) begin
          r_s1     <= 1'b0;
          r_s2     <= 1'b0;
          r_stable <= 1'b0;
          r_rise   <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (w_accept) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
            r_rise   <= r_s2;   // only a 0->1 acceptance pulses
          end else if (w_diff) begin
            r_cnt  <= r_cnt + CNT_ONE;
            r_rise <= 1'b0;
          end else begin
            r_cnt  <= '0;
            r_rise <= 1'b0;
          end
        end
      end

      assign w_lvl[gi]  = r_stable;
      assign w_rise[gi] = r_rise;
    end
  endgenerate

  // Nine-bit sum so two simultaneous glitches from 254 are seen as overflow.
  assign w_gsum = {1'b0, r_gcnt} + 9'(w_glitch[0]) + 9'(w_glitch[1]);

  // Saturating glitch counter shared by both channels.
  always_ff @(posedge CLK_clk_i or negedge RST_rst_i) begin
    if (!RST_rst_i) begin
      r_gcnt <= 8'd0;
    end else if (w_gsum[8]) begin
      r_gcnt <= 8'hFF;
    end else begin
      r_gcnt <= w_gsum[7:0];
    end
  end

  assign Temp_lvl_o   = w_lvl[0];
  assign Humo_lvl_o   = w_lvl[1];
  assign Temp_rise_o  = w_rise[0];
  assign Humo_rise_o  = w_rise[1];
  assign Glitch_cnt_o = r_gcnt;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed scenarios plus randomized bursts, every
// edge compared against a sample-history reference model.
module tb_sensor_conditioner;

  localparam int DB   = 8;
  localparam int MAXH = 8192;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw_t = 1'b0;
  logic       raw_h = 1'b0;
  logic       temp_lvl, humo_lvl, temp_rise, humo_rise;
  logic [7:0] gcnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: synchroniser delay line, decision-sample history
  // since the last reset, expected outputs.
  logic m_p1   [2];
  logic m_p2   [2];
  logic m_lvl  [2];
  logic m_rise [2];
  int   m_gc;
  logic hist   [2][0:MAXH-1];
  int   hlen;

  sensor_conditioner #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .CLK_clk_i    (clk),
    .RST_rst_i    (rst_n),
    .Sensor_Temp_i(raw_t),
    .Sensor_Humo_i(raw_h),
    .Temp_lvl_o   (temp_lvl),
    .Humo_lvl_o   (humo_lvl),
    .Temp_rise_o  (temp_rise),
    .Humo_rise_o  (humo_rise),
    .Glitch_cnt_o (gcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_p1[c] = 1'b0; m_p2[c] = 1'b0; m_lvl[c] = 1'b0; m_rise[c] = 1'b0;
    end
    m_gc = 0;
    hlen = 0;
  endtask

  // Level flips once the last DB decision samples all disagree with it;
  // a glitch is a sample agreeing with the level right after one that did not.
  task automatic model_step(input logic rt, input logic rh);
    logic raw [2];
    logic samp;
    bit   acc;
    int   ng;
    raw[0] = rt; raw[1] = rh;
    ng = 0;
    if (hlen >= MAXH) begin
      $display("FAIL model_history observed=%0d expected<%0d", hlen, MAXH);
      $fatal(1);
    end
    for (int c = 0; c < 2; c++) begin
      samp      = m_p2[c];
      m_p2[c]   = m_p1[c];
      m_p1[c]   = raw[c];
      hist[c][hlen] = samp;
      if (samp == m_lvl[c] && hlen >= 1 && hist[c][hlen-1] != m_lvl[c]) ng++;
      acc = (hlen + 1 >= DB);
      if (acc)
        for (int k = 0; k < DB; k++)
          if (hist[c][hlen-k] == m_lvl[c]) acc = 0;
      if (acc) begin
        m_lvl[c]  = samp;
        m_rise[c] = samp;
      end else begin
        m_rise[c] = 1'b0;
      end
    end
    hlen++;
    m_gc = (m_gc + ng > 255) ? 255 : m_gc + ng;
  endtask

  task automatic compare_all();
    check("temp_lvl",  32'(temp_lvl),  int'(m_lvl[0]));
    check("humo_lvl",  32'(humo_lvl),  int'(m_lvl[1]));
    check("temp_rise", 32'(temp_rise), int'(m_rise[0]));
    check("humo_rise", 32'(humo_rise), int'(m_rise[1]));
    check("glitch_cnt", 32'(gcnt), m_gc);
  endtask

  // One clock edge, model step, full comparison one time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step(raw_t, raw_h);
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_temp_lvl"},  32'(temp_lvl),  0);
    check({tag, "_humo_lvl"},  32'(humo_lvl),  0);
    check({tag, "_temp_rise"}, 32'(temp_rise), 0);
    check({tag, "_humo_rise"}, 32'(humo_rise), 0);
    check({tag, "_gcnt"},      32'(gcnt),      0);
  endtask

  // Asynchronous assert between edges, hold for n edges, release between edges.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    rst_n = 1'b1;
  endtask

  // Ticks until channel level equals target; reports first index and pulses.
  task automatic measure(input int ch, input logic target, input int n,
                         output int first_at, output int npulse);
    first_at = 0;
    npulse   = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (((ch == 0) ? temp_lvl : humo_lvl) === target && first_at == 0) first_at = i;
      npulse += int'((ch == 0) ? temp_rise : humo_rise);
    end
  endtask

  task automatic glitch(input logic t, input logic h);
    raw_t = t; raw_h = h;
    tick(); tick();
    raw_t = 1'b0; raw_h = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    int ft, fh, pt, ph, both, g0, hold_t, hold_h;
    model_reset();

    // Reset with both raw lines high, then one clean rise per channel.
    raw_t = 1'b1; raw_h = 1'b1;
    do_reset(3);
    ft = 0; fh = 0; pt = 0; ph = 0; both = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (temp_lvl === 1'b1 && ft == 0) ft = i;
      if (humo_lvl === 1'b1 && fh == 0) fh = i;
      pt += int'(temp_rise); ph += int'(humo_rise);
      both += int'(temp_rise & humo_rise);
    end
    check("reset_temp_latency", 32'(ft), 10);
    check("reset_humo_latency", 32'(fh), 10);
    check("reset_temp_pulses", 32'(pt), 1);
    check("reset_humo_pulses", 32'(ph), 1);
    check("reset_both_pulse", 32'(both), 1);
    $display("step: reset release accept temp@%0d humo@%0d", ft, fh);

    // Clean accept and clean falling accept on temperature.
    raw_t = 1'b0; raw_h = 1'b0;
    do_reset(2);
    raw_t = 1'b1;
    measure(0, 1'b1, 20, ft, pt);
    check("clean_rise_latency", 32'(ft), 10);
    check("clean_rise_pulses", 32'(pt), 1);
    raw_t = 1'b0;
    measure(0, 1'b0, 20, ft, pt);
    check("clean_fall_latency", 32'(ft), 10);
    check("clean_fall_pulses", 32'(pt), 0);
    check("clean_gcnt", 32'(gcnt), 0);
    $display("step: clean accept done");

    // Glitch reject on smoke, then a bounce followed by a real rise.
    raw_h = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    raw_h = 1'b0;
    ph = 0;
    for (int i = 0; i < 6; i++) begin tick(); ph += int'(humo_rise); end
    check("glitch_humo_lvl", 32'(humo_lvl), 0);
    check("glitch_humo_pulses", 32'(ph), 0);
    check("glitch_gcnt1", 32'(gcnt), 1);
    raw_h = 1'b1; tick(); tick();
    raw_h = 1'b0; tick();
    raw_h = 1'b1;
    measure(1, 1'b1, 14, fh, ph);
    check("bounce_latency", 32'(fh), 10);
    check("bounce_pulses", 32'(ph), 1);
    check("bounce_gcnt2", 32'(gcnt), 2);
    $display("step: glitch reject done gcnt=%0d", gcnt);

    // Simultaneous glitches on both channels count two.
    raw_t = 1'b0; raw_h = 1'b0;
    do_reset(2);
    glitch(1'b1, 1'b1);
    check("dual_glitch_gcnt", 32'(gcnt), 2);
    $display("step: dual glitch gcnt=%0d", gcnt);

    // Saturation after 300 single-channel glitches.
    do_reset(2);
    for (int i = 0; i < 300; i++) glitch(1'b0, 1'b1);
    check("sat300_gcnt", 32'(gcnt), 255);
    check("sat300_humo_lvl", 32'(humo_lvl), 0);
    $display("step: 300 glitches gcnt=%0d", gcnt);

    // 254 then a double glitch lands exactly on 255.
    do_reset(2);
    for (int i = 0; i < 254; i++) glitch(1'b1, 1'b0);
    check("pre254_gcnt", 32'(gcnt), 254);
    glitch(1'b1, 1'b1);
    check("sat254p2_gcnt", 32'(gcnt), 255);
    g0 = int'(gcnt);
    glitch(1'b1, 1'b1);
    check("sat_hold_gcnt", 32'(gcnt), g0);
    $display("step: preload saturation gcnt=%0d", gcnt);

    // Reset mid-debounce discards the partial count.
    do_reset(2);
    raw_t = 1'b1;
    pt = 0;
    for (int i = 0; i < 6; i++) begin tick(); pt += int'(temp_rise); end
    check("middb_pre_pulses", 32'(pt), 0);
    do_reset(2);
    measure(0, 1'b1, 14, ft, pt);
    check("middb_latency", 32'(ft), 10);
    check("middb_pulses", 32'(pt), 1);
    $display("step: reset mid-debounce accept@%0d", ft);

    // Randomized bursts on both channels against the model.
    raw_t = 1'b0; raw_h = 1'b0;
    do_reset(2);
    hold_t = 0; hold_h = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold_t == 0) begin raw_t = 1'($urandom_range(0, 1)); hold_t = int'($urandom_range(1, 12)); end
      if (hold_h == 0) begin raw_h = 1'($urandom_range(0, 1)); hold_h = int'($urandom_range(1, 12)); end
      hold_t--; hold_h--;
      tick();
    end
    $display("step: random bursts done gcnt=%0d", gcnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
